// File: rtl/pwd_candidate_gen.sv
// ---------------------------------------------------------------------------
// pwd_candidate_gen
//   Walks a contiguous, inclusive range of fixed-width ASCII-decimal password
//   candidates and presents one per cycle to a SHA256 hash-compare core over a
//   valid/ready handshake. Each hash core owns one instance loaded with its own
//   [base, limit] slice; a global stop aborts the sweep once any core matches.
//
// Ports
//   clk         in   rising-edge system clock
//   reset       in   synchronous, active-high reset
//   start       in   one-cycle pulse: latch base/limit and begin a sweep
//   base        in   first candidate, ASCII '0'..'9', most significant digit in top byte
//   limit       in   last candidate (inclusive), same encoding
//   stop        in   abort the running sweep
//   cand_valid  out  cand_data holds a candidate
//   cand_ready  in   consumer accepts cand_data this cycle
//   cand_data   out  current candidate (ASCII)
//   cand_cnt    out  candidates accepted since the last start, saturating
//   busy        out  sweep in progress
//   exhausted   out  limit was accepted, or the range was empty
//   err         out  base or limit contained a non-digit byte at start
// ---------------------------------------------------------------------------
module pwd_candidate_gen #(
  parameter int DIGITS = 9,
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [8*DIGITS-1:0] base,
  input  logic [8*DIGITS-1:0] limit,
  input  logic                stop,
  output logic                cand_valid,
  input  logic                cand_ready,
  output logic [8*DIGITS-1:0] cand_data,
  output logic [CNT_W-1:0]    cand_cnt,
  output logic                busy,
  output logic                exhausted,
  output logic                err
);

  localparam int W = 8 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [W-1:0]     cur_reg, lim_reg;
  logic [W-1:0]     cur_inc;
  logic [CNT_W-1:0] cnt_reg;
  logic             exhausted_reg, err_reg;

  logic [DIGITS:0]   carry;
  logic [DIGITS-1:0] base_ok, limit_ok;
  logic              digits_ok, range_empty;
  logic              in_run, handshake, at_limit, carry_out, accept_start;

  // Per-byte digit validation and ASCII-decimal ripple increment.
  // carry[gi] means every byte below gi was '9' and has rolled to '0'.
  assign carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [7:0] cur_byte;
      logic       is_nine;

      assign cur_byte = cur_reg[8*gi +: 8];
      assign is_nine  = (cur_byte == 8'h39);

      assign base_ok[gi]  = (base[8*gi +: 8]  >= 8'h30) && (base[8*gi +: 8]  <= 8'h39);
      assign limit_ok[gi] = (limit[8*gi +: 8] >= 8'h30) && (limit[8*gi +: 8] <= 8'h39);

      assign cur_inc[8*gi +: 8] = !carry[gi] ? cur_byte :
                                  is_nine    ? 8'h30    : cur_byte + 8'd1;
      assign carry[gi+1] = carry[gi] && is_nine;
    end
  endgenerate

  // Equal-length ASCII digit strings order the same as their unsigned values.
  assign digits_ok    = (&base_ok) && (&limit_ok);
  assign range_empty  = (base > limit);
  assign in_run       = (state_reg == S_RUN);
  assign handshake    = in_run && cand_ready;
  assign at_limit     = (cur_reg == lim_reg);
  // Unreachable while cur <= lim, but a carry out of the MSD ends the sweep.
  assign carry_out    = carry[DIGITS];
  assign accept_start = start && !in_run;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; stop outranks limit completion in RUN.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next = (!digits_ok || range_empty) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_next = S_DONE;
        end else if (handshake && (at_limit || carry_out)) begin
          state_next = S_DONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: candidate, limit, counter and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_reg       <= '0;
      lim_reg       <= '0;
      cnt_reg       <= '0;
      exhausted_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else if (accept_start) begin
      cur_reg       <= base;
      lim_reg       <= limit;
      cnt_reg       <= '0;
      err_reg       <= !digits_ok;
      exhausted_reg <= digits_ok && range_empty;
    end else if (in_run) begin
      // A handshake coincident with stop is still counted.
      if (handshake && (cnt_reg != {CNT_W{1'b1}})) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      // On stop the last presented candidate stays on cand_data.
      if (handshake && !stop) begin
        if (at_limit || carry_out) begin
          exhausted_reg <= 1'b1;
        end else begin
          cur_reg <= cur_inc;
        end
      end
    end
  end

  // Outputs
  always_comb begin
    cand_valid = in_run;
    busy       = in_run;
    cand_data  = cur_reg;
    cand_cnt   = cnt_reg;
    exhausted  = exhausted_reg;
    err        = err_reg;
  end

endmodule
